// File: rtl/test_end_monitor.sv
`default_nettype none
// ============================================================================
// Module   : test_end_monitor
// Purpose  : End-of-test monitor for multi-core test harnesses. It watches
//            per-channel done/fail levels and progress pulses, enforces a
//            cycle-limit timeout and a progress (stall) watchdog, and
//            produces a sticky pass/fail verdict with a reason code. It also
//            provides a waveform-dump window enable.
// Ports    : clock, reset (async, active-low)
//            ch_done/ch_fail/ch_progress/done_mask [NUM_CH] - channel inputs
//            max_cycles/dump_start [CYC_W], stall_limit [STALL_W] - config
//            cycle_count [CYC_W], state [2], finish, pass, fail,
//            fail_code [2], fail_ch [5], dump_enable - registered outputs
// Revision : 1.0 - initial release
// ============================================================================
module test_end_monitor #(
    parameter int NUM_CH      = 4,
    parameter int CYC_W       = 64,
    parameter int HOLD_CYCLES = 16,
    parameter int STALL_W     = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_CH-1:0]  ch_done,
    input  logic [NUM_CH-1:0]  ch_fail,
    input  logic [NUM_CH-1:0]  ch_progress,
    input  logic [NUM_CH-1:0]  done_mask,
    input  logic [CYC_W-1:0]   max_cycles,
    input  logic [STALL_W-1:0] stall_limit,
    input  logic [CYC_W-1:0]   dump_start,
    output logic [CYC_W-1:0]   cycle_count,
    output logic [1:0]         state,
    output logic               finish,
    output logic               pass,
    output logic               fail,
    output logic [1:0]         fail_code,
    output logic [4:0]         fail_ch,
    output logic               dump_enable
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'b00,
        ST_RUN  = 2'b01,
        ST_PASS = 2'b10,
        ST_FAIL = 2'b11
    } state_t;

    localparam logic [1:0]       C_CODE_CH      = 2'b01;
    localparam logic [1:0]       C_CODE_STALL   = 2'b10;
    localparam logic [1:0]       C_CODE_TIMEOUT = 2'b11;
    localparam logic [CYC_W-1:0] C_HOLD_LAST    = CYC_W'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CYC_W-1:0]   cycle_q, cycle_d;
    logic [NUM_CH-1:0]  done_lat_q, done_lat_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               finish_q, finish_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic [1:0]         code_q, code_d;
    logic [4:0]         fail_ch_q, fail_ch_d;
    logic               dump_q, dump_d;

    logic               active, in_run;
    logic               chfail_hit, stall_hit, timeout_hit, pass_cond;
    logic               progress_hit;
    logic [4:0]         fail_idx;

    // Lowest-index failing channel: scan downwards so the lowest set bit wins.
    always_comb begin
        fail_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_fail[i]) begin
                fail_idx = 5'(i);
            end
        end
    end

    always_comb begin
        active       = (state_q == ST_HOLD) || (state_q == ST_RUN);
        in_run       = (state_q == ST_RUN);
        chfail_hit   = in_run && (ch_fail != '0);
        // The counter never moves in HOLD, so a nonzero limit cannot hit there.
        stall_hit    = active && (stall_limit != '0) && (stall_q == stall_limit);
        timeout_hit  = active && (max_cycles != '0) && (cycle_q == max_cycles);
        // A done pulse in the same cycle counts, not only latched completions.
        pass_cond    = in_run && (done_mask != '0) &&
                       (((done_lat_q | ch_done) & done_mask) == done_mask);
        // Only progress from channels still expected to finish feeds the watchdog.
        progress_hit = (ch_progress & done_mask & ~done_lat_q) != '0;
    end

    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        done_lat_d = done_lat_q;
        stall_d    = stall_q;
        finish_d   = 1'b0;
        pass_d     = pass_q;
        fail_d     = fail_q;
        code_d     = code_q;
        fail_ch_d  = fail_ch_q;
        dump_d     = dump_q;

        if (active) begin
            if (in_run) begin
                done_lat_d = done_lat_q | ch_done;
                if (progress_hit) begin
                    stall_d = '0;
                end else if (stall_q != '1) begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end

            if (chfail_hit) begin
                state_d   = ST_FAIL;
                fail_d    = 1'b1;
                code_d    = C_CODE_CH;
                fail_ch_d = fail_idx;
            end else if (stall_hit) begin
                state_d = ST_FAIL;
                fail_d  = 1'b1;
                code_d  = C_CODE_STALL;
            end else if (timeout_hit) begin
                state_d = ST_FAIL;
                fail_d  = 1'b1;
                code_d  = C_CODE_TIMEOUT;
            end else if (pass_cond) begin
                state_d = ST_PASS;
                pass_d  = 1'b1;
            end

            if (chfail_hit || stall_hit || timeout_hit || pass_cond) begin
                // cycle_count freezes at the detection value; dump window closes.
                finish_d = 1'b1;
                dump_d   = 1'b0;
            end else begin
                cycle_d = cycle_q + CYC_W'(1);
                if (cycle_q == dump_start) begin
                    dump_d = 1'b1;
                end
                if ((state_q == ST_HOLD) && (cycle_q == C_HOLD_LAST)) begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_HOLD;
            cycle_q    <= '0;
            done_lat_q <= '0;
            stall_q    <= '0;
            finish_q   <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            code_q     <= '0;
            fail_ch_q  <= '0;
            dump_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            done_lat_q <= done_lat_d;
            stall_q    <= stall_d;
            finish_q   <= finish_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            code_q     <= code_d;
            fail_ch_q  <= fail_ch_d;
            dump_q     <= dump_d;
        end
    end

    assign cycle_count = cycle_q;
    assign state       = state_q;
    assign finish      = finish_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_code   = code_q;
    assign fail_ch     = fail_ch_q;
    assign dump_enable = dump_q;

endmodule
`default_nettype wire

// File: tb/tb_test_end_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_end_monitor
// Purpose  : Self-checking bench for test_end_monitor. Stimulus drives directed
//            and randomized scenarios; a reference model derived from the
//            verdict rules pushes the expected end-of-test record into a
//            scoreboard queue, and a monitor pops and compares on finish.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_end_monitor;

    localparam int NUM_CH  = 4;
    localparam int CYC_W   = 64;
    localparam int HOLD    = 16;
    localparam int STALL_W = 32;

    localparam int M_RAND  = 0;
    localparam int M_SEQ   = 1;
    localparam int M_TMO   = 2;
    localparam int M_CHF   = 3;
    localparam int M_STALL = 4;
    localparam int M_HOLD  = 5;
    localparam int M_ABORT = 6;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_CH-1:0]  ch_done = '0, ch_fail = '0, ch_progress = '0, done_mask = '0;
    logic [CYC_W-1:0]   max_cycles = '0, dump_start = '0;
    logic [STALL_W-1:0] stall_limit = '0;
    logic [CYC_W-1:0]   cycle_count;
    logic [1:0]         state, fail_code;
    logic               finish, pass, fail, dump_enable;
    logic [4:0]         fail_ch;

    test_end_monitor #(
        .NUM_CH(NUM_CH), .CYC_W(CYC_W), .HOLD_CYCLES(HOLD), .STALL_W(STALL_W)
    ) dut (
        .clock(clock), .reset(reset),
        .ch_done(ch_done), .ch_fail(ch_fail), .ch_progress(ch_progress),
        .done_mask(done_mask), .max_cycles(max_cycles),
        .stall_limit(stall_limit), .dump_start(dump_start),
        .cycle_count(cycle_count), .state(state), .finish(finish),
        .pass(pass), .fail(fail), .fail_code(fail_code), .fail_ch(fail_ch),
        .dump_enable(dump_enable)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]       st;
        logic [1:0]       code;
        logic [4:0]       ch;
        logic [CYC_W-1:0] cyc;
        logic             dump_before;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    // ---------------- monitor: pops an expectation on every finish pulse
    logic dump_prev = 1'b0;
    exp_t mon_e;
    always @(negedge clock) begin
        if (reset && finish) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_finish: finish=1 with nothing expected, cycle_count=%0d", cycle_count);
            end else begin
                mon_e = sb_q.pop_front();
                check("end_state",      state,       mon_e.st);
                check("end_pass",       pass,        mon_e.st == 2'b10);
                check("end_fail",       fail,        mon_e.st == 2'b11);
                check("end_fail_code",  fail_code,   mon_e.code);
                check("end_cycle",      cycle_count, mon_e.cyc);
                check("end_dump_low",   dump_enable, 0);
                check("dump_before",    dump_prev,   mon_e.dump_before);
                if (mon_e.code == 2'b01) check("end_fail_ch", fail_ch, mon_e.ch);
            end
        end
        dump_prev <= dump_enable;
    end

    // ---------------- one test: async reset, run to a verdict (or abort)
    task automatic run_test(input int mode, input logic [3:0] mask, input longint maxc,
                            input int stl, input longint dst, input int abort_at);
        logic [3:0] dn, fi, pg, db;
        int         lastp, start, fa;
        bit         term, run;
        exp_t       e;

        // Asynchronous reset away from any clock edge: outputs must clear at once.
        #2;
        reset = 1'b0;
        #1;
        check("rst_state",  state,       0);
        check("rst_cycle",  cycle_count, 0);
        check("rst_flags",  {finish, pass, fail, dump_enable}, 0);
        check("rst_code",   {fail_code, fail_ch}, 0);

        ch_done = '0; ch_fail = '0; ch_progress = '0;
        done_mask   = mask;
        max_cycles  = CYC_W'(maxc);
        stall_limit = STALL_W'(stl);
        dump_start  = CYC_W'(dst);
        @(posedge clock);
        #1;
        reset = 1'b1;

        db = '0; lastp = -1; term = 0;
        fa = $urandom_range(HOLD, 500);
        e = '{st: 2'b00, code: 2'b00, ch: 5'd0, cyc: '0, dump_before: 1'b0};
        for (int c = 0; c < 3000; c++) begin
            dn = '0; fi = '0; pg = '0;
            case (mode)
                M_RAND: begin
                    for (int i = 0; i < 4; i++) dn[i] = ($urandom_range(0, 63) == 0);
                    if (c > fa && $urandom_range(0, 149) == 0) fi = 4'($urandom_range(1, 15));
                    pg = 4'($urandom & $urandom & $urandom);
                end
                M_SEQ: dn = (c == 100) ? 4'b0001 : (c == 120) ? 4'b0010 :
                            (c == 130) ? 4'b0100 : (c == 140) ? 4'b1000 : 4'b0000;
                M_TMO: begin
                    dn = (c == 50) ? 4'b0001 : 4'b0000;
                    pg = 4'($urandom);
                end
                M_CHF: begin
                    dn = (c == 200) ? 4'b0001 : 4'b0000;
                    fi = (c == 200) ? 4'b1010 : 4'b0000;
                end
                M_STALL: begin
                    pg = (c % 40 == 0 && c <= 300) ? 4'b0001 : 4'b0000;
                    if (c > 300) pg[2] = $urandom_range(0, 1) == 1;   // unmasked: no effect
                end
                M_HOLD: begin
                    fi = (c < HOLD) ? 4'b0001 : 4'b0000;
                    dn = (c == 800) ? 4'b1111 : 4'b0000;
                end
                default: pg = 4'($urandom);
            endcase
            ch_done = dn; ch_fail = fi; ch_progress = pg;

            if (c == HOLD - 1) check("state_hold_last", state, 0);
            if (c == HOLD) begin
                check("state_run_entry", state, 1);
                check("cycle_at_run",    cycle_count, c);
            end
            if (c == abort_at) break;

            // Reference verdict for cycle c
            run   = (c >= HOLD);
            start = (lastp >= 0) ? lastp + 1 : HOLD;
            e.cyc = CYC_W'(c);
            e.dump_before = (dst < c);
            if (run && fi != 0) begin
                term = 1; e.st = 2'b11; e.code = 2'b01; e.ch = 5'(lowest(fi));
            end else if (stl != 0 && run && (c - start) == stl) begin
                term = 1; e.st = 2'b11; e.code = 2'b10;
            end else if (maxc != 0 && c == maxc) begin
                term = 1; e.st = 2'b11; e.code = 2'b11;
            end else if (run && mask != 0 && ((db | dn) & mask) == mask) begin
                term = 1; e.st = 2'b10; e.code = 2'b00;
            end
            if (term) sb_q.push_back(e);

            if (run) begin
                if ((pg & mask & ~db) != 0) lastp = c;
                db = db | dn;
            end

            @(posedge clock);
            #1;
            if (term) break;
        end

        if (term) begin
            for (int k = 0; k < 4; k++) begin
                if (sb_q.size() == 0) break;
                @(negedge clock);
            end
            if (sb_q.size() != 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL finish_timeout: no finish pulse, expected verdict at cycle %0d", e.cyc);
                sb_q.delete();
            end
            // Verdict must be absorbing: later channel activity is ignored.
            repeat (3) begin
                ch_fail = 4'($urandom_range(1, 15));
                ch_done = 4'($urandom);
                @(posedge clock);
                #1;
            end
            check("finish_single", finish,      0);
            check("absorb_state",  state,       e.st);
            check("absorb_cycle",  cycle_count, e.cyc);
            check("absorb_code",   fail_code,   e.code);
            check("absorb_dump",   dump_enable, 0);
        end
        ch_done = '0; ch_fail = '0; ch_progress = '0;
    endtask

    initial begin
        run_test(M_SEQ,   4'b1111,   0,  0,    5, -1);
        run_test(M_TMO,   4'b0011, 500,  0,  100, -1);
        run_test(M_CHF,   4'b0001,   0,  0,    0, -1);
        run_test(M_STALL, 4'b0001,   0, 50,   20, -1);
        run_test(M_HOLD,  4'b1111,   0,  0, 1000, -1);
        run_test(M_ABORT, 4'b1111,   0,  0,   10, 60);
        run_test(M_SEQ,   4'b1111,   0,  0,    0, -1);
        for (int t = 0; t < 8; t++) begin
            run_test(M_RAND, 4'($urandom_range(0, 15)), longint'($urandom_range(100, 700)),
                     ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(20, 80)),
                     longint'($urandom_range(0, 400)), -1);
        end
        #2;
        reset = 1'b0;
        #1;
        check("final_reset_state", state, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
